seg_scan_decoder: RTL and testbench

- Receive side of the multiplexed seven-segment display bus: snoops the active-low segment lines and digit selects driven toward the board display.
- Per-digit debounce, then decodes each segment pattern back to its hex nibble.
- Publishes a per-digit value/valid array and a valid/ready update stream.
- Used by the NPC test harness to read back what the display shows.

---
 rtl/seg_scan_decoder.sv | 239 +++++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Seven-segment bus snooper: debounces each multiplexed digit,
// decodes the glyph to hex and publishes values plus an update stream.
module seg_scan_decoder #(
  parameter int NDIG   = 8,
  parameter int STABLE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        seg_n,
  input  logic [NDIG-1:0]   an_n,
  output logic [4*NDIG-1:0] digits,
  output logic [NDIG-1:0]   dp,
  output logic [NDIG-1:0]   dig_valid,
  output logic              upd_valid,
  output logic [3:0]        upd_idx,
  output logic [3:0]        upd_nib,
  input  logic              upd_ready,
  output logic              frame_pulse,
  output logic [2:0]        err,
  input  logic              err_clr
);

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    LOCKED
  } state_t;

  state_t          state;
  logic [7:0]      seg_s;
  logic [NDIG-1:0] an_s;
  logic [3:0]      lidx;
  logic [7:0]      lseg;
  logic [7:0]      cnt;
  logic [NDIG-1:0] seen;

  logic [4:0]      nz;
  logic [3:0]      sel;
  logic            legal;
  logic            multi;
  logic            same;
  logic [7:0]      cnt_inc;
  logic            commit_now;

  logic [6:0]      on;
  logic [4:0]      g;
  logic            hit;
  logic            blank;
  logic            cdp;
  logic [15:0]     vld16;
  logic [15:0]     dp16;
  logic [63:0]     dig64;
  logic            ev_new;
  logic            accept;
  logic [NDIG-1:0] cmask;
  logic [NDIG-1:0] seen_nx;

  function automatic logic [4:0] glyph(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b1111110: r = {1'b1, 4'h0};
      7'b0110000: r = {1'b1, 4'h1};
      7'b1101101: r = {1'b1, 4'h2};
      7'b1111001: r = {1'b1, 4'h3};
      7'b0110011: r = {1'b1, 4'h4};
      7'b1011011: r = {1'b1, 4'h5};
      7'b1011111: r = {1'b1, 4'h6};
      7'b1110000: r = {1'b1, 4'h7};
      7'b1111111: r = {1'b1, 4'h8};
      7'b1110011: r = {1'b1, 4'h9};
      7'b1110111: r = {1'b1, 4'hA};
      7'b0011111: r = {1'b1, 4'hB};
      7'b1001110: r = {1'b1, 4'hC};
      7'b0111101: r = {1'b1, 4'hD};
      7'b1001111: r = {1'b1, 4'hE};
      7'b1000111: r = {1'b1, 4'hF};
      default:    r = 5'd0;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_s <= '1;
      an_s  <= '1;
    end else begin
      seg_s <= seg_n;
      an_s  <= an_n;
    end
  end

  always_comb begin
    nz  = 5'd0;
    sel = 4'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (!an_s[i]) begin
        nz  = nz + 5'd1;
        sel = 4'(i);
      end
    end
  end

  assign legal   = (nz == 5'd1);
  assign multi   = (nz > 5'd1);
  assign same    = (sel == lidx) && (seg_s == lseg);
  assign cnt_inc = cnt + 8'd1;

  assign commit_now = (state == TRACK) && legal && same &&
                      (cnt_inc == 8'(STABLE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lidx  <= 4'd0;
      lseg  <= '1;
      cnt   <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (legal) begin
            lidx  <= sel;
            lseg  <= seg_s;
            cnt   <= 8'd1;
            state <= TRACK;
          end
        end
        TRACK: begin
          if (!legal) begin
            state <= IDLE;
          end else if (!same) begin
            lidx <= sel;
            lseg <= seg_s;
            cnt  <= 8'd1;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == 8'(STABLE))
              state <= LOCKED;
          end
        end
        LOCKED: begin
          if (!legal) begin
            state <= IDLE;
          end else if (!same) begin
            lidx  <= sel;
            lseg  <= seg_s;
            cnt   <= 8'd1;
            state <= TRACK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign on    = ~lseg[7:1];
  assign g     = glyph(on);
  assign hit   = g[4];
  assign blank = (on == 7'd0);
  assign cdp   = ~lseg[0];
  assign vld16 = 16'(dig_valid);
  assign dp16  = 16'(dp);
  assign dig64 = 64'(digits);

  // Only a visible change of a recognised glyph is worth an event
  assign ev_new = commit_now && hit &&
                  (!vld16[lidx] ||
                   (dig64[{lidx, 2'b00} +: 4] != g[3:0]) ||
                   (dp16[lidx] != cdp));

  assign accept = upd_valid & upd_ready;

  always_comb begin
    cmask = '0;
    for (int i = 0; i < NDIG; i++)
      cmask[i] = commit_now && (lidx == 4'(i));
  end

  assign seen_nx = seen | cmask;

  always_ff @(posedge clk) begin
    if (rst) begin
      digits    <= '0;
      dp        <= '0;
      dig_valid <= '0;
    end else if (commit_now) begin
      for (int i = 0; i < NDIG; i++) begin
        if (lidx == 4'(i)) begin
          if (hit) begin
            digits[4*i +: 4] <= g[3:0];
            dp[i]            <= cdp;
            dig_valid[i]     <= 1'b1;
          end else begin
            dig_valid[i] <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      upd_valid <= 1'b0;
      upd_idx   <= 4'd0;
      upd_nib   <= 4'd0;
    end else if (ev_new && (!upd_valid || accept)) begin
      upd_valid <= 1'b1;
      upd_idx   <= lidx;
      upd_nib   <= g[3:0];
    end else if (accept) begin
      upd_valid <= 1'b0;
    end
  end

  // A commit on the pulse edge belongs to the frame just closed
  always_ff @(posedge clk) begin
    if (rst) begin
      seen        <= '0;
      frame_pulse <= 1'b0;
    end else if (&seen_nx) begin
      seen        <= '0;
      frame_pulse <= 1'b1;
    end else begin
      seen        <= seen_nx;
      frame_pulse <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 3'd0;
    end else begin
      err <= (err_clr ? 3'd0 : err) |
             {ev_new && upd_valid && !accept,
              multi,
              commit_now && !hit && !blank};
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: glyph commits, debounce,
// error flags, update handshake, frame pulse and reset.
module tb_seg_scan_decoder;

  localparam int NDIG   = 8;
  localparam int STABLE = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        seg_n;
  logic [NDIG-1:0]   an_n;
  logic [4*NDIG-1:0] digits;
  logic [NDIG-1:0]   dp;
  logic [NDIG-1:0]   dig_valid;
  logic              upd_valid;
  logic [3:0]        upd_idx;
  logic [3:0]        upd_nib;
  logic              upd_ready;
  logic              frame_pulse;
  logic [2:0]        err;
  logic              err_clr;

  int checks = 0;
  int errors = 0;

  logic [6:0] gl [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  seg_scan_decoder #(
    .NDIG  (NDIG),
    .STABLE(STABLE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .digits     (digits),
    .dp         (dp),
    .dig_valid  (dig_valid),
    .upd_valid  (upd_valid),
    .upd_idx    (upd_idx),
    .upd_nib    (upd_nib),
    .upd_ready  (upd_ready),
    .frame_pulse(frame_pulse),
    .err        (err),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] s);
    an_n  = a;
    seg_n = s;
  endtask

  task automatic pop();
    upd_ready = 1'b1;
    tick(1);
    upd_ready = 1'b0;
  endtask

  function automatic logic [7:0] seg_of(input int nib, input logic d);
    logic [6:0] t;
    t = gl[nib];
    return {~t, ~d};
  endfunction

  initial begin
    int pulses;
    int pulse_at;
    logic [7:0] a;

    rst       = 1'b1;
    upd_ready = 1'b0;
    err_clr   = 1'b0;
    drive(8'hFF, 8'hFF);
    tick(3);
    chk("rst_digits", 64'(digits), 64'h0);
    chk("rst_valid", 64'(dig_valid), 64'h0);
    chk("rst_dp", 64'(dp), 64'h0);
    chk("rst_upd", 64'(upd_valid), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_frame", 64'(frame_pulse), 64'h0);

    // digit 0 shows "0"
    rst = 1'b0;
    drive(8'hFE, 8'h03);
    tick(4);
    chk("pre_commit", 64'(dig_valid), 64'h0);
    tick(1);
    chk("d0_nib", 64'(digits[3:0]), 64'h0);
    chk("d0_valid", 64'(dig_valid), 64'h01);
    chk("d0_dp", 64'(dp[0]), 64'h0);
    chk("d0_uv", 64'(upd_valid), 64'h1);
    chk("d0_uidx", 64'(upd_idx), 64'h0);
    chk("d0_unib", 64'(upd_nib), 64'h0);
    pop();
    chk("d0_pop", 64'(upd_valid), 64'h0);
    tick(20);
    chk("dwell_upd", 64'(upd_valid), 64'h0);
    chk("dwell_valid", 64'(dig_valid), 64'h01);

    // digit 3 shows "A"
    drive(8'hF7, 8'h11);
    tick(5);
    chk("d3_nib", 64'(digits[15:12]), 64'hA);
    chk("d3_valid", 64'(dig_valid), 64'h09);
    chk("d3_uidx", 64'(upd_idx), 64'h3);
    chk("d3_unib", 64'(upd_nib), 64'hA);
    pop();

    // short glitch never commits
    drive(8'hFF, 8'hFF);
    tick(3);
    drive(8'hFE, 8'h9F);
    tick(3);
    drive(8'hFF, 8'hFF);
    tick(10);
    chk("glitch_nib", 64'(digits[3:0]), 64'h0);
    chk("glitch_upd", 64'(upd_valid), 64'h0);
    chk("glitch_valid", 64'(dig_valid), 64'h09);

    // digit 2: "1", then blank, then unknown glyph
    drive(8'hFB, 8'h9F);
    tick(5);
    chk("d2_valid", 64'(dig_valid), 64'h0D);
    chk("d2_unib", 64'(upd_nib), 64'h1);
    pop();
    drive(8'hFB, 8'hFF);
    tick(5);
    chk("blank_valid", 64'(dig_valid), 64'h09);
    chk("blank_err", 64'(err), 64'h0);
    chk("blank_upd", 64'(upd_valid), 64'h0);
    drive(8'hFB, 8'hFD);
    tick(5);
    chk("unk_err", 64'(err), 64'h1);
    chk("unk_valid", 64'(dig_valid), 64'h09);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("clr_err", 64'(err), 64'h0);
    drive(8'hFE, 8'h02);
    tick(5);
    chk("dp_on", 64'(dp), 64'h01);
    chk("dp_nib", 64'(digits[3:0]), 64'h0);
    chk("dp_uv", 64'(upd_valid), 64'h1);
    chk("dp_uidx", 64'(upd_idx), 64'h0);
    pop();

    // two digits selected at once
    drive(8'hFC, 8'h03);
    tick(10);
    chk("multi_err", 64'(err), 64'h2);
    chk("multi_valid", 64'(dig_valid), 64'h09);
    chk("multi_upd", 64'(upd_valid), 64'h0);
    drive(8'hFF, 8'hFF);
    err_clr = 1'b1;
    tick(1);
    chk("clr_vs_event", 64'(err), 64'h2);
    tick(1);
    err_clr = 1'b0;
    chk("clr_after", 64'(err), 64'h0);

    // backpressure and overflow
    drive(8'hFE, seg_of(5, 1'b0));
    tick(5);
    chk("bp_first_idx", 64'(upd_idx), 64'h0);
    chk("bp_first_nib", 64'(upd_nib), 64'h5);
    drive(8'hFD, seg_of(7, 1'b0));
    tick(5);
    chk("ovf_uv", 64'(upd_valid), 64'h1);
    chk("ovf_idx", 64'(upd_idx), 64'h0);
    chk("ovf_nib", 64'(upd_nib), 64'h5);
    chk("ovf_err", 64'(err), 64'h4);
    chk("ovf_d1", 64'(digits[7:4]), 64'h7);
    chk("ovf_valid", 64'(dig_valid), 64'h0B);
    drive(8'hFB, seg_of(8, 1'b0));
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(3);
    upd_ready = 1'b1;
    tick(1);
    chk("swap_uv", 64'(upd_valid), 64'h1);
    chk("swap_idx", 64'(upd_idx), 64'h2);
    chk("swap_nib", 64'(upd_nib), 64'h8);
    chk("swap_err", 64'(err), 64'h0);
    tick(1);
    chk("swap_pop", 64'(upd_valid), 64'h0);

    // reset while tracking
    upd_ready = 1'b0;
    drive(8'hBF, 8'h03);
    tick(3);
    rst = 1'b1;
    tick(1);
    chk("mid_digits", 64'(digits), 64'h0);
    chk("mid_valid", 64'(dig_valid), 64'h0);
    chk("mid_dp", 64'(dp), 64'h0);
    chk("mid_upd", 64'(upd_valid), 64'h0);
    chk("mid_err", 64'(err), 64'h0);
    rst = 1'b0;
    drive(8'hFF, 8'hFF);
    tick(6);
    chk("post_rst_valid", 64'(dig_valid), 64'h0);

    // full scan closes exactly one frame
    upd_ready = 1'b1;
    pulses    = 0;
    pulse_at  = -1;
    for (int d = 0; d < NDIG; d++) begin
      a = ~(8'(1) << d);
      drive(a, seg_of(d, 1'b0));
      for (int e = 1; e <= STABLE + 2; e++) begin
        tick(1);
        if (frame_pulse) begin
          pulses++;
          pulse_at = d * 10 + e;
        end
      end
    end
    chk("frame_count", 64'(pulses), 64'd1);
    chk("frame_edge", 64'(pulse_at), 64'd75);
    chk("frame_digits", 64'(digits), 64'h76543210);
    chk("frame_valid", 64'(dig_valid), 64'hFF);
    drive(8'hFF, 8'hFF);
    tick(1);
    chk("frame_quiet", 64'(frame_pulse), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
